// File: rtl/anfield_wb_bridge.sv
// Purpose : bridges a core's fetch, load and store requests onto one Wishbone
//           master port. Partial-mask stores are done as read-merge-write.
// Latency : strobe starts 1 cycle after a request is sampled in IDLE. The
//           result/pulse is visible 1 cycle after ack, or 1 cycle after timeout.
// Backpressure: core requests are levels sampled only in IDLE. Read data is held
//           with rd_ready_o until rd_shake_i. The bus is stalled by withholding
//           wb_ack_i, and the stall is bounded by TIMEOUT_CYCLES.
// Ports   : clk/rst_n; inst_* fetch channel; rd_*/raddr/rdata read channel with
//           handshake; wr_*/waddr/wdata/wmask write channel; bus_err_o timeout
//           pulse; wb_* Wishbone master (classic, single outstanding cycle).
module anfield_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_req_i,
    input  logic [ADDR_WIDTH-1:0]   inst_addr_i,
    output logic [DATA_WIDTH-1:0]   inst_o,
    output logic                    inst_ready_o,
    input  logic                    rd_req_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rd_ready_o,
    input  logic                    rd_shake_i,
    input  logic                    wr_req_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    output logic                    wr_done_o,
    output logic                    bus_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, INST, DRD, RMW_RD, RMW_GAP, WR, RD_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;   // store data; overwritten with merged word after RMW read
    logic [MASK_WIDTH-1:0] mask_q;
    logic [CNT_WIDTH-1:0]  tmo_cnt;
    logic [DATA_WIDTH-1:0] merged;

    logic stb_phase;
    logic ack;
    logic tmo;

    // Strobe is a pure function of state, so an ack outside these states never
    // reaches any state or data update.
    assign stb_phase = (state == INST) || (state == DRD) ||
                       (state == RMW_RD) || (state == WR);
    assign ack       = stb_phase && wb_ack_i;
    // This cycle is the TIMEOUT_CYCLES-th strobe cycle without ack. An ack in
    // the same cycle wins because the term requires !wb_ack_i.
    assign tmo       = stb_phase && !wb_ack_i &&
                       (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    assign wb_addr_o = addr_q & ~ADDR_WIDTH'(3);
    assign wb_dat_o  = data_q;

    // Enabled bytes come from the store data; the rest come from the word just read.
    always_comb begin
        merged = data_q;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (!mask_q[i]) begin
                merged[8*i +: 8] = wb_dat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req_i) begin
                    state_nxt = (&wmask_i) ? WR : RMW_RD;
                end else if (rd_req_i) begin
                    state_nxt = DRD;
                end else if (inst_req_i) begin
                    state_nxt = INST;
                end
            end
            INST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (ack || tmo) state_nxt = IDLE;
            end
            DRD: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (ack || tmo) state_nxt = RD_HOLD;
            end
            RMW_RD: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (ack)      state_nxt = RMW_GAP;
                else if (tmo) state_nxt = IDLE;   // aborted: skip the write phase
            end
            RMW_GAP: begin
                wb_cyc_o  = 1'b1;                 // keep the bus locked between read and write
                state_nxt = WR;
            end
            WR: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                if (ack || tmo) state_nxt = IDLE;
            end
            RD_HOLD: begin
                if (rd_shake_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter is zero whenever strobe is low, so every strobe phase starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!stb_phase || wb_ack_i) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            inst_o       <= '0;
            inst_ready_o <= 1'b0;
            rdata_o      <= '0;
            rd_ready_o   <= 1'b0;
            wr_done_o    <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            inst_ready_o <= 1'b0;
            wr_done_o    <= 1'b0;
            bus_err_o    <= tmo;

            if (state == IDLE && state_nxt != IDLE) begin
                addr_q <= wr_req_i ? waddr_i : (rd_req_i ? raddr_i : inst_addr_i);
                data_q <= wdata_i;
                mask_q <= wmask_i;
            end

            case (state)
                INST: begin
                    if (ack || tmo) begin
                        inst_o       <= ack ? wb_dat_i : '0;
                        inst_ready_o <= 1'b1;
                    end
                end
                DRD: begin
                    if (ack || tmo) begin
                        rdata_o    <= ack ? wb_dat_i : '0;
                        rd_ready_o <= 1'b1;
                    end
                end
                RMW_RD: begin
                    if (ack) begin
                        data_q <= merged;
                    end else if (tmo) begin
                        wr_done_o <= 1'b1;
                    end
                end
                WR: begin
                    if (ack || tmo) wr_done_o <= 1'b1;
                end
                RD_HOLD: begin
                    if (rd_shake_i) rd_ready_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_anfield_wb_bridge.sv
module tb_anfield_wb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    localparam int K_STB  = 1;
    localparam int K_GAP  = 2;
    localparam int K_ERR  = 3;
    localparam int K_INST = 4;
    localparam int K_RD   = 5;
    localparam int K_HOLD = 6;
    localparam int K_WR   = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req_i;
    logic [AW-1:0] inst_addr_i;
    logic [DW-1:0] inst_o;
    logic          inst_ready_o;
    logic          rd_req_i;
    logic [AW-1:0] raddr_i;
    logic [DW-1:0] rdata_o;
    logic          rd_ready_o;
    logic          rd_shake_i;
    logic          wr_req_i;
    logic [AW-1:0] waddr_i;
    logic [DW-1:0] wdata_i;
    logic [3:0]    wmask_i;
    logic          wr_done_o;
    logic          bus_err_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    logic          slave_ack;
    logic          stray_ack;
    logic [DW-1:0] slave_rdata;
    int            ack_lat;      // ack in the ack_lat-th strobe cycle; -1 never acks
    int            slave_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } ev_t;

    ev_t exp_q[$];

    anfield_wb_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_req_i  (inst_req_i),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_o),
        .inst_ready_o(inst_ready_o),
        .rd_req_i    (rd_req_i),
        .raddr_i     (raddr_i),
        .rdata_o     (rdata_o),
        .rd_ready_o  (rd_ready_o),
        .rd_shake_i  (rd_shake_i),
        .wr_req_i    (wr_req_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .wmask_i     (wmask_i),
        .wr_done_o   (wr_done_o),
        .bus_err_o   (bus_err_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_addr_o   (wb_addr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
    );

    assign wb_ack_i = slave_ack | stray_ack;
    assign wb_dat_i = slave_rdata;

    initial forever #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_STB:   return "stb_phase";
            K_GAP:   return "rmw_gap";
            K_ERR:   return "bus_err";
            K_INST:  return "inst_ready";
            K_RD:    return "rd_ready";
            K_HOLD:  return "rd_hold";
            K_WR:    return "wr_done";
            default: return "none";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected %s: got %h/%h/%h/%h, required no event",
                     kname(k), a, b, c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.b !== b || e.c !== c || e.d !== d) begin
                fails++;
                $display("FAIL %s: got %s %h/%h/%h/%h, required %s %h/%h/%h/%h",
                         kname(e.kind), kname(k), a, b, c, d,
                         kname(e.kind), e.a, e.b, e.c, e.d);
            end
        end
    endtask

    // Wishbone slave: acks in the ack_lat-th consecutive strobe cycle.
    initial begin
        slave_ack = 1'b0;
        slave_cnt = 0;
        forever begin
            @(negedge clk);
            if (wb_stb_o) begin
                slave_cnt = slave_cnt + 1;
                slave_ack = (slave_cnt == ack_lat);
            end else begin
                slave_cnt = 0;
                slave_ack = 1'b0;
            end
        end
    end

    // Monitor: turns DUT output activity into events and checks them in order.
    initial begin
        int          stb_len;
        int          hold_len;
        logic        prev_stb;
        logic        prev_rdy;
        logic        cap_we;
        logic        hold_chg;
        logic [31:0] cap_addr;
        logic [31:0] cap_dat;
        logic [31:0] hold_dat;
        stb_len = 0; hold_len = 0; prev_stb = 1'b0; prev_rdy = 1'b0;
        cap_we = 1'b0; hold_chg = 1'b0; cap_addr = '0; cap_dat = '0; hold_dat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stb_len = 0; hold_len = 0; prev_stb = 1'b0; prev_rdy = 1'b0;
            end else begin
                if (wb_stb_o) begin
                    stb_len  = stb_len + 1;
                    cap_we   = wb_we_o;
                    cap_addr = wb_addr_o;
                    cap_dat  = wb_we_o ? wb_dat_o : 32'h0;
                end else if (prev_stb) begin
                    observe(K_STB, 32'(stb_len), {31'b0, cap_we}, cap_addr, cap_dat);
                    stb_len = 0;
                end
                if (wb_cyc_o && !wb_stb_o) observe(K_GAP, 0, 0, 0, 0);
                if (bus_err_o)             observe(K_ERR, 0, 0, 0, 0);
                if (inst_ready_o)          observe(K_INST, inst_o, 0, 0, 0);
                if (rd_ready_o) begin
                    if (!prev_rdy) begin
                        observe(K_RD, rdata_o, 0, 0, 0);
                        hold_len = 0;
                        hold_chg = 1'b0;
                        hold_dat = rdata_o;
                    end
                    hold_len = hold_len + 1;
                    if (rdata_o !== hold_dat) hold_chg = 1'b1;
                end else if (prev_rdy) begin
                    observe(K_HOLD, 32'(hold_len), {31'b0, hold_chg}, 0, 0);
                end
                if (wr_done_o) observe(K_WR, 0, 0, 0, 0);
                prev_stb = wb_stb_o;
                prev_rdy = rd_ready_o;
            end
        end
    end

    // which: 0 cyc high, 1 wr_done, 2 rd_ready, 3 inst_ready, 4 cyc high with stb low
    task automatic wait_for(input int which, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = wb_cyc_o;
                1:       hit = wr_done_o;
                2:       hit = rd_ready_o;
                3:       hit = inst_ready_o;
                default: hit = wb_cyc_o && !wb_stb_o;
            endcase
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL timeout %s: not seen within 200 cycles, required to occur", nm);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        inst_req_i = 1'b0; inst_addr_i = '0;
        rd_req_i = 1'b0;   raddr_i = '0; rd_shake_i = 1'b0;
        wr_req_i = 1'b0;   waddr_i = '0; wdata_i = '0; wmask_i = '0;
        stray_ack = 1'b0;  slave_rdata = '0; ack_lat = -1;

        repeat (3) @(negedge clk);
        chk("reset cyc",        {31'b0, wb_cyc_o}, 0);
        chk("reset stb",        {31'b0, wb_stb_o}, 0);
        chk("reset we",         {31'b0, wb_we_o}, 0);
        chk("reset addr",       wb_addr_o, 0);
        chk("reset wdat",       wb_dat_o, 0);
        chk("reset inst",       inst_o, 0);
        chk("reset inst_ready", {31'b0, inst_ready_o}, 0);
        chk("reset rdata",      rdata_o, 0);
        chk("reset rd_ready",   {31'b0, rd_ready_o}, 0);
        chk("reset wr_done",    {31'b0, wr_done_o}, 0);
        chk("reset bus_err",    {31'b0, bus_err_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch, unaligned address, ack in 3rd strobe cycle
        ack_lat = 3; slave_rdata = 32'h0000_0013;
        expect_ev(K_STB, 3, 0, 32'h0000_1004, 0);
        expect_ev(K_INST, 32'h0000_0013, 0, 0, 0);
        inst_addr_i = 32'h0000_1006; inst_req_i = 1'b1;
        wait_for(0, "fetch start");
        inst_req_i = 1'b0;
        wait_for(3, "fetch done");
        repeat (2) @(negedge clk);

        // Partial write: read, gap, merged write
        ack_lat = 2; slave_rdata = 32'h1122_3344;
        expect_ev(K_STB, 2, 0, 32'h0000_2000, 0);
        expect_ev(K_GAP, 0, 0, 0, 0);
        expect_ev(K_STB, 2, 1, 32'h0000_2000, 32'h1122_CC44);
        expect_ev(K_WR, 0, 0, 0, 0);
        waddr_i = 32'h0000_2000; wdata_i = 32'hAABB_CCDD; wmask_i = 4'b0010; wr_req_i = 1'b1;
        wait_for(0, "rmw start");
        wr_req_i = 1'b0;
        wait_for(1, "rmw done");
        repeat (2) @(negedge clk);

        // Simultaneous requests: write, then read (held 6 cycles), then fetch
        ack_lat = 1; slave_rdata = 32'h600D_F00D;
        expect_ev(K_STB, 1, 1, 32'h0000_3000, 32'hCAFE_F00D);
        expect_ev(K_WR, 0, 0, 0, 0);
        expect_ev(K_STB, 1, 0, 32'h0000_4000, 0);
        expect_ev(K_RD, 32'h600D_F00D, 0, 0, 0);
        expect_ev(K_HOLD, 6, 0, 0, 0);
        expect_ev(K_STB, 1, 0, 32'h0000_5004, 0);
        expect_ev(K_INST, 32'h600D_F00D, 0, 0, 0);
        waddr_i = 32'h0000_3001; wdata_i = 32'hCAFE_F00D; wmask_i = 4'hF;
        raddr_i = 32'h0000_4002; inst_addr_i = 32'h0000_5007;
        wr_req_i = 1'b1; rd_req_i = 1'b1; inst_req_i = 1'b1;
        wait_for(1, "prio write done");
        wr_req_i = 1'b0;
        wait_for(2, "prio read ready");
        rd_req_i = 1'b0;
        repeat (5) @(negedge clk);
        rd_shake_i = 1'b1;
        @(negedge clk);
        rd_shake_i = 1'b0;
        wait_for(3, "prio fetch done");
        inst_req_i = 1'b0;
        repeat (2) @(negedge clk);

        // Read timeout: strobe 8 cycles, error, data 0
        ack_lat = -1; slave_rdata = 32'hDEAD_BEEF;
        expect_ev(K_STB, 8, 0, 32'h0000_7000, 0);
        expect_ev(K_ERR, 0, 0, 0, 0);
        expect_ev(K_RD, 0, 0, 0, 0);
        expect_ev(K_HOLD, 1, 0, 0, 0);
        raddr_i = 32'h0000_7000; rd_req_i = 1'b1;
        wait_for(0, "tmo read start");
        rd_req_i = 1'b0;
        wait_for(2, "tmo read ready");
        rd_shake_i = 1'b1;
        @(negedge clk);
        rd_shake_i = 1'b0;
        repeat (2) @(negedge clk);

        // Ack on the 8th strobe cycle wins over timeout
        ack_lat = 8; slave_rdata = 32'h8888_0001;
        expect_ev(K_STB, 8, 0, 32'h0000_7100, 0);
        expect_ev(K_RD, 32'h8888_0001, 0, 0, 0);
        expect_ev(K_HOLD, 1, 0, 0, 0);
        raddr_i = 32'h0000_7100; rd_req_i = 1'b1;
        wait_for(0, "late ack start");
        rd_req_i = 1'b0;
        wait_for(2, "late ack ready");
        rd_shake_i = 1'b1;
        @(negedge clk);
        rd_shake_i = 1'b0;
        repeat (2) @(negedge clk);

        // RMW read timeout: no write phase, wr_done still pulses
        ack_lat = -1;
        expect_ev(K_STB, 8, 0, 32'h0000_B000, 0);
        expect_ev(K_ERR, 0, 0, 0, 0);
        expect_ev(K_WR, 0, 0, 0, 0);
        waddr_i = 32'h0000_B000; wdata_i = 32'h0102_0304; wmask_i = 4'b1100; wr_req_i = 1'b1;
        wait_for(0, "tmo rmw start");
        wr_req_i = 1'b0;
        wait_for(1, "tmo rmw done");
        repeat (2) @(negedge clk);

        // Stray ack while idle must do nothing
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        chk("stray ack cyc", {31'b0, wb_cyc_o}, 0);
        repeat (2) @(negedge clk);

        // Reset during RMW gap, then a normal fetch
        ack_lat = 1; slave_rdata = 32'h1234_5678;
        expect_ev(K_STB, 1, 0, 32'h0000_9000, 0);
        expect_ev(K_GAP, 0, 0, 0, 0);
        waddr_i = 32'h0000_9000; wdata_i = 32'h0000_00FF; wmask_i = 4'b0001; wr_req_i = 1'b1;
        wait_for(0, "gap rmw start");
        wr_req_i = 1'b0;
        wait_for(4, "gap reached");
        #2 rst_n = 1'b0;
        #1;
        chk("midreset cyc",   {31'b0, wb_cyc_o}, 0);
        chk("midreset stb",   {31'b0, wb_stb_o}, 0);
        chk("midreset we",    {31'b0, wb_we_o}, 0);
        chk("midreset addr",  wb_addr_o, 0);
        chk("midreset wdat",  wb_dat_o, 0);
        chk("midreset inst",  inst_o, 0);
        chk("midreset rdata", rdata_o, 0);
        repeat (2) @(negedge clk);
        ack_lat = 2; slave_rdata = 32'h00C0_FFEE;
        expect_ev(K_STB, 2, 0, 32'h0000_A008, 0);
        expect_ev(K_INST, 32'h00C0_FFEE, 0, 0, 0);
        inst_addr_i = 32'h0000_A00B; inst_req_i = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first req after reset", {31'b0, wb_cyc_o}, 1);
        inst_req_i = 1'b0;
        wait_for(3, "post-reset fetch done");

        repeat (10) @(negedge clk);
        chk("events drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
